// File: rtl/vreg_wb_sched_if.sv
// Bundle of requester, write-port, reservation and hazard-query signals
// between the execute/memory units and the vector register write-back scheduler.
interface vreg_wb_sched_if #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_reg;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        gnt;

    logic                   reg_write;
    logic [ADDR_W-1:0]      write_reg;
    logic [DATA_W-1:0]      write_data;

    logic                   rsv_valid;
    logic [ADDR_W-1:0]      rsv_reg;
    logic                   rsv_stall;

    logic [ADDR_W-1:0]      query_reg1;
    logic [ADDR_W-1:0]      query_reg2;
    logic                   busy1;
    logic                   busy2;

    modport master (
        output req, req_reg, req_data, rsv_valid, rsv_reg, query_reg1, query_reg2,
        input  gnt, reg_write, write_reg, write_data, rsv_stall, busy1, busy2
    );

    modport slave (
        input  req, req_reg, req_data, rsv_valid, rsv_reg, query_reg1, query_reg2,
        output gnt, reg_write, write_reg, write_data, rsv_stall, busy1, busy2
    );
endinterface

// File: rtl/vreg_wb_sched.sv
// Round-robin write-back scheduler for the vector register file write port,
// with a per-register pending scoreboard for RAW/WAW hazard detection.
module vreg_wb_sched #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic            clk,
    input logic            rst,
    vreg_wb_sched_if.slave bus
);
    localparam int PTR_W = $clog2(NREQ);
    localparam int NREG  = 1 << ADDR_W;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NREG-1:0]   pending_q, pending_d;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    logic              gnt_any;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W:0]    cand;
    logic [NREQ-1:0]   gnt_vec;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;
    logic              rsv_stall;
    logic              rsv_take;

    // Search starts at rr_ptr and wraps; cand is one bit wider so the wrap is a subtract.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NREQ)) begin
                cand = cand - (PTR_W+1)'(NREQ);
            end
            if (!gnt_any && bus.req[cand[PTR_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[PTR_W-1:0];
            end
        end
        if (rst) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        gnt_vec  = '0;
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_any && (gnt_idx == PTR_W'(i))) begin
                gnt_vec[i] = 1'b1;
                sel_reg    = bus.req_reg[i*ADDR_W +: ADDR_W];
                sel_data   = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rsv_stall = bus.rsv_valid && (bus.rsv_reg != '0) && pending_q[bus.rsv_reg];
    assign rsv_take  = bus.rsv_valid && (bus.rsv_reg != '0) && !pending_q[bus.rsv_reg];

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (gnt_any) begin
            rr_ptr_d     = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
            reg_write_d  = (sel_reg != '0);
            write_reg_d  = sel_reg;
            write_data_d = sel_data;
        end
    end

    // Clear first, then set, so a fresh reservation wins over a retiring write.
    always_comb begin
        pending_d = pending_q;
        if (reg_write_q) begin
            pending_d[write_reg_q] = 1'b0;
        end
        if (rsv_take) begin
            pending_d[bus.rsv_reg] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            pending_q    <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            pending_q    <= pending_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign bus.gnt        = gnt_vec;
    assign bus.reg_write  = reg_write_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;
    assign bus.rsv_stall  = rsv_stall;
    assign bus.busy1      = pending_q[bus.query_reg1];
    assign bus.busy2      = pending_q[bus.query_reg2];
endmodule

// File: tb/tb_vreg_wb_sched.sv
// Bench for vreg_wb_sched: directed scenarios followed by randomized traffic,
// all checked against a cycle-level behavioural model of the scheduler.
module tb_vreg_wb_sched;
    localparam int NREQ   = 3;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vreg_wb_sched_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    vreg_wb_sched #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors = 0;
    int errors  = 0;

    // Behavioural model state
    bit          pend[32];
    int          rr = 0;
    bit          m_we = 1'b0;
    logic [4:0]  m_wreg = '0;
    logic [31:0] m_wdata = '0;

    // Requester and issue-side stimulus
    bit          r_req[NREQ];
    logic [4:0]  r_reg[NREQ];
    logic [31:0] r_data[NREQ];
    bit          rv = 1'b0;
    logic [4:0]  rreg = '0;
    logic [4:0]  q1 = '0;
    logic [4:0]  q2 = '0;

    int          last_gnt = -1;
    logic [31:0] obs_gnt, obs_stall, obs_busy1, obs_busy2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i] = r_req[i];
            bus.req_reg[i*ADDR_W +: ADDR_W] = r_reg[i];
            bus.req_data[i*DATA_W +: DATA_W] = r_data[i];
        end
        bus.rsv_valid  = rv;
        bus.rsv_reg    = rreg;
        bus.query_reg1 = q1;
        bus.query_reg2 = q2;
    endtask

    function automatic int model_pick();
        if (rst) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (rr + k) % NREQ;
            if (r_req[i]) return i;
        end
        return -1;
    endfunction

    // One clock: check combinational outputs mid-cycle, advance model, check registered outputs.
    task automatic cycle();
        int          g;
        bit          stall;
        bit          nxt[32];
        logic [4:0]  g_reg;
        logic [31:0] g_data;
        drive();
        #2;
        g = model_pick();
        stall = rv && (rreg != 0) && pend[rreg];
        obs_gnt   = 32'(bus.gnt);
        obs_stall = 32'(bus.rsv_stall);
        obs_busy1 = 32'(bus.busy1);
        obs_busy2 = 32'(bus.busy2);
        chk("gnt", obs_gnt, (g < 0) ? 32'd0 : 32'(1 << g));
        chk("rsv_stall", obs_stall, 32'(stall));
        chk("busy1", obs_busy1, 32'(pend[q1]));
        chk("busy2", obs_busy2, 32'(pend[q2]));
        g_reg  = (g >= 0) ? r_reg[g] : 5'd0;
        g_data = (g >= 0) ? r_data[g] : 32'd0;
        last_gnt = g;
        @(posedge clk);
        #1;
        if (rst) begin
            foreach (pend[r]) pend[r] = 1'b0;
            rr = 0; m_we = 1'b0; m_wreg = '0; m_wdata = '0;
        end else begin
            nxt = pend;
            if (m_we) nxt[m_wreg] = 1'b0;
            if (rv && (rreg != 0) && !pend[rreg]) nxt[rreg] = 1'b1;
            pend = nxt;
            if (g >= 0) begin
                rr = (g + 1) % NREQ;
                m_we = (g_reg != 0);
                m_wreg = g_reg;
                m_wdata = g_data;
            end else begin
                m_we = 1'b0;
            end
        end
        chk("reg_write", 32'(bus.reg_write), 32'(m_we));
        chk("write_reg", 32'(bus.write_reg), 32'(m_wreg));
        chk("write_data", bus.write_data, m_wdata);
    endtask

    task automatic retire();
        if (last_gnt >= 0) r_req[last_gnt] = 1'b0;
    endtask

    initial begin
        logic [31:0] seq_exp [6];
        seq_exp[0] = 32'd1; seq_exp[1] = 32'd2; seq_exp[2] = 32'd4;
        seq_exp[3] = 32'd1; seq_exp[4] = 32'd2; seq_exp[5] = 32'd4;
        foreach (pend[r]) pend[r] = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            r_req[i] = 1'b0; r_reg[i] = '0; r_data[i] = '0;
        end
        drive();
        @(posedge clk);
        #1;

        // Reset held two cycles, then idle scan of every query index
        cycle();
        cycle();
        chk("rst_reg_write", 32'(bus.reg_write), 32'd0);
        rst = 1'b0;
        for (int q = 0; q < 32; q++) begin
            q1 = 5'(q);
            q2 = 5'(31 - q);
            cycle();
            chk("idle_busy1", obs_busy1, 32'd0);
        end

        // Single write to reg 7
        rv = 1'b1; rreg = 5'd7; q1 = 5'd7; q2 = 5'd0;
        cycle();
        rv = 1'b0;
        cycle();
        chk("busy7_c1", obs_busy1, 32'd1);
        r_req[1] = 1'b1; r_reg[1] = 5'd7; r_data[1] = 32'hDEADBEEF;
        cycle();
        chk("single_gnt", obs_gnt, 32'd2);
        chk("single_busy_c2", obs_busy1, 32'd1);
        chk("single_we", 32'(bus.reg_write), 32'd1);
        chk("single_wreg", 32'(bus.write_reg), 32'd7);
        chk("single_wdata", bus.write_data, 32'hDEADBEEF);
        retire();
        cycle();
        chk("busy7_c3", obs_busy1, 32'd1);
        cycle();
        chk("busy7_c4", obs_busy1, 32'd0);

        // Round-robin from a fresh pointer with all requesters held high
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            r_req[i] = 1'b1; r_reg[i] = 5'(i + 1); r_data[i] = $urandom;
        end
        for (int s = 0; s < 6; s++) begin
            cycle();
            chk("rr_order", obs_gnt, seq_exp[s]);
            if (last_gnt >= 0) r_data[last_gnt] = $urandom;
        end
        for (int i = 0; i < NREQ; i++) r_req[i] = 1'b0;

        // WAW stall on reg 5 across its retiring write
        rv = 1'b1; rreg = 5'd5; q1 = 5'd5;
        cycle();
        chk("waw_first", obs_stall, 32'd0);
        r_req[0] = 1'b1; r_reg[0] = 5'd5; r_data[0] = 32'h5555AAAA;
        cycle();
        chk("waw_stall", obs_stall, 32'd1);
        retire();
        cycle();
        chk("waw_stall_commit", obs_stall, 32'd1);
        chk("waw_commit_we", 32'(bus.reg_write), 32'd0);
        cycle();
        chk("waw_accept", obs_stall, 32'd0);
        rv = 1'b0;
        cycle();
        chk("waw_busy5", obs_busy1, 32'd1);

        // Register 0 write and reservation
        r_req[0] = 1'b1; r_reg[0] = 5'd0; r_data[0] = 32'h1234;
        rv = 1'b1; rreg = 5'd0; q1 = 5'd0;
        cycle();
        chk("r0_gnt", obs_gnt, 32'd1);
        chk("r0_stall", obs_stall, 32'd0);
        chk("r0_busy", obs_busy1, 32'd0);
        chk("r0_we", 32'(bus.reg_write), 32'd0);
        retire();
        rv = 1'b0;

        // Reset mid-operation
        rv = 1'b1; rreg = 5'd12;
        cycle();
        rv = 1'b0;
        r_req[1] = 1'b1; r_reg[1] = 5'd9; r_data[1] = 32'h0BAD0BAD;
        rst = 1'b1;
        cycle();
        chk("rst_mid_gnt", obs_gnt, 32'd0);
        chk("rst_mid_we", 32'(bus.reg_write), 32'd0);
        rst = 1'b0;
        r_req[0] = 1'b1; r_reg[0] = 5'd3; r_data[0] = 32'h33;
        r_req[2] = 1'b1; r_reg[2] = 5'd4; r_data[2] = 32'h44;
        q1 = 5'd12; q2 = 5'd5;
        cycle();
        chk("rst_mid_restart", obs_gnt, 32'd1);
        chk("rst_mid_busy12", obs_busy1, 32'd0);
        chk("rst_mid_busy5", obs_busy2, 32'd0);
        for (int i = 0; i < NREQ; i++) r_req[i] = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!r_req[i] && ($urandom_range(0, 2) == 0)) begin
                    r_req[i]  = 1'b1;
                    r_reg[i]  = 5'($urandom_range(0, 31));
                    r_data[i] = $urandom;
                end
            end
            rv   = 1'($urandom_range(0, 1));
            rreg = 5'($urandom_range(0, 31));
            q1   = 5'($urandom_range(0, 31));
            q2   = ($urandom_range(0, 1) == 0) ? m_wreg : 5'($urandom_range(0, 31));
            rst  = ($urandom_range(0, 99) == 0);
            cycle();
            retire();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
